conv_enc: RTL

Rate-1/2, constraint-length-3 convolutional encoder (generators 7,5 octal) that frames user bits into fixed 31-bit blocks and emits one 2-bit symbol per clock toward the QAM mapper. It is the transmit-side counterpart of `inv_conv`: the trellis starts in state 0 at every block boundary, and the block-length/symbol bit ordering match what `inv_conv` expects. A small input FIFO decouples the bursty bit source from the continuous symbol stream.

---
 rtl/conv_enc.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/conv_enc.sv
// Rate-1/2, K=3 convolutional encoder (generators 7,5 octal) with an input bit FIFO.
// Emits one 2-bit symbol per clock in fixed BLOCK_LEN-symbol blocks, trellis zeroed at each block start.
module conv_enc #(
  parameter int unsigned BLOCK_LEN  = 31,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger_encode,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic [1:0] conv_out,
  output logic       conv_valid,
  output logic       block_start,
  output logic       underrun
);

  localparam int unsigned IDX_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_LEN - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [1:0]         r_s;
  logic [IDX_W-1:0]   r_idx;
  logic [1:0]         r_conv_out;
  logic               r_conv_valid;
  logic               r_block_start;
  logic               r_underrun;
  logic               r_bit_ready;

  logic [FIFO_DEPTH-1:0] r_mem;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_active;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_first;
  logic               w_last;
  logic               w_u;
  logic [1:0]         w_s_eff;
  logic [1:0]         w_sym;
  logic [1:0]         w_s_nxt;
  logic [CNT_W-1:0]   w_count_nxt;

  assign w_empty = (r_count == CNT_W'(0));
  assign w_first = (r_idx == IDX_W'(0));
  assign w_last  = (r_idx == LAST_IDX);

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; a drain only ends once the last symbol of the block is issued
  always_comb begin
    w_state_nxt = r_state;
    w_active    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (trigger_encode && !w_empty) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_active = 1'b1;
        if (!trigger_encode) begin
          w_state_nxt = w_last ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_active = 1'b1;
        if (trigger_encode) begin
          w_state_nxt = ST_RUN;
        end else if (w_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Encoder datapath and FIFO handshake; an empty FIFO feeds u = 0
  always_comb begin
    w_push      = bit_valid & r_bit_ready;
    w_pop       = w_active & ~w_empty;
    w_u         = w_empty ? 1'b0 : r_mem[r_rd_ptr];
    w_s_eff     = w_first ? 2'b00 : r_s;
    w_sym       = {w_u ^ w_s_eff[0], w_u ^ w_s_eff[1] ^ w_s_eff[0]};
    w_s_nxt     = {w_u, w_s_eff[1]};
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Input FIFO storage and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem       <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_bit_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= bit_in;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count     <= w_count_nxt;
      r_bit_ready <= (w_count_nxt != FULL_CNT);
    end
  end

  // Trellis state, block index and registered symbol outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s           <= 2'b00;
      r_idx         <= '0;
      r_conv_out    <= 2'b00;
      r_conv_valid  <= 1'b0;
      r_block_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_conv_valid  <= w_active;
      r_block_start <= w_active & w_first;
      if (w_active) begin
        r_conv_out <= w_sym;
        r_s        <= w_s_nxt;
        r_idx      <= w_last ? IDX_W'(0) : r_idx + IDX_W'(1);
        if (w_empty) begin
          r_underrun <= 1'b1;
        end
      end else begin
        r_idx <= IDX_W'(0);
      end
    end
  end

  assign bit_ready   = r_bit_ready;
  assign conv_out    = r_conv_out;
  assign conv_valid  = r_conv_valid;
  assign block_start = r_block_start;
  assign underrun    = r_underrun;

endmodule
